hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, register-specifier width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum consecutive memory-wait cycles before halt; legal range 1..1023.
REQ-003 SHALL have parameter CNT_BITS, default 32, stall-counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 id_ex_mem_read_i  input  1  instruction in ID/EX is a load.
REQ-008 id_ex_rt_i  input  REG_BITS  load destination register.
REQ-009 if_id_rs_i  input  REG_BITS  rs of instruction in IF/ID.
REQ-010 if_id_rt_i  input  REG_BITS  rt of instruction in IF/ID.
REQ-011 mem_busy_i  input  1  data memory not ready; access must be held.
REQ-012 branch_taken_i  input  1  taken branch/jump resolved this cycle.
REQ-013 pc_disenabler_o  output  1  1 = program counter holds its value.
REQ-014 if_id_disenabler_o  output  1  1 = IF/ID register holds.
REQ-015 ex_mem_disenabler_o  output  1  1 = EX/MEM register holds.
REQ-016 id_ex_flush_o  output  1  1 = insert bubble into ID/EX.
REQ-017 if_id_flush_o  output  1  1 = squash IF/ID contents.
REQ-018 mem_timeout_o  output  1  sticky; memory wait exceeded TIMEOUT_CYCLES.
REQ-019 stall_count_o  output  CNT_BITS  stall-cycle count (present only per REQ-034).

Function
REQ-020 SHALL implement states IDLE, MEM_WAIT, HALT; reset state IDLE.
REQ-021 Load-use hazard H SHALL be id_ex_mem_read_i AND id_ex_rt_i!=0 AND (id_ex_rt_i==if_id_rs_i OR id_ex_rt_i==if_id_rt_i).
REQ-022 IDLE, mem_busy_i=0, branch_taken_i=0: pc_disenabler_o=if_id_disenabler_o=id_ex_flush_o=H, same cycle, combinational; ex_mem_disenabler_o=0.
REQ-023 IDLE, mem_busy_i=0, branch_taken_i=1: if_id_flush_o=1, id_ex_flush_o=H, pc_disenabler_o=if_id_disenabler_o=0 (branch overrides load-use stall).
REQ-024 mem_busy_i=1 in IDLE or MEM_WAIT: pc_disenabler_o=if_id_disenabler_o=ex_mem_disenabler_o=1, id_ex_flush_o=0, if_id_flush_o=0, same cycle; H ignored; next state MEM_WAIT.
REQ-025 MEM_WAIT with mem_busy_i=0: outputs per REQ-022/023/026 in that cycle; next state IDLE.
REQ-026 branch_taken_i=1 in any cycle where mem_busy_i=1 SHALL set a pending flag; if_id_flush_o SHALL pulse exactly one cycle in the first cycle with mem_busy_i=0, then the flag clears; multiple branches while stalled produce one pulse.
REQ-027 Wait counter SHALL be 0 in IDLE, increment each MEM_WAIT cycle with mem_busy_i=1; reaching TIMEOUT_CYCLES SHALL move to HALT next edge.
REQ-028 HALT: mem_timeout_o=1, pc/if_id/ex_mem disenablers=1, both flushes=0, regardless of inputs; exit only by reset.

Reset
REQ-029 Reset assertion SHALL asynchronously force state IDLE, wait counter 0, pending flag 0, mem_timeout_o=0, stall counter 0.
REQ-030 During reset all outputs SHALL be 0.
REQ-031 Reset asserted mid-MEM_WAIT or in HALT SHALL discard pending branch flush; no if_id_flush_o pulse after release.
REQ-032 First cycle after release SHALL evaluate REQ-022..024 from inputs only.

Configuration
REQ-033 Macro STALL_COUNTER_EN SHALL control the stall counter.
REQ-034 Defined: stall_count_o present; +1 each cycle pc_disenabler_o=1, saturates at all-ones. Undefined: port and counter absent; all other behaviour identical.

Verification
REQ-035 Load-use: mem_read=1, id_ex_rt=8, if_id_rs=8 -> pc/if_id disenabler and id_ex_flush =1 same cycle; id_ex_rt=0 -> all 0.
REQ-036 Memory wait: mem_busy_i=1 for 3 cycles -> three disenablers =1 for exactly 3 cycles, id_ex_flush=0, state back to IDLE next edge.
REQ-037 Branch during wait: branch_taken_i=1 in cycle 2 of 4-cycle busy -> if_id_flush_o=1 only in first non-busy cycle, width 1.
REQ-038 Timeout: TIMEOUT_CYCLES=4, busy held -> HALT after 4 wait cycles, mem_timeout_o=1 sticky after busy drops; reset clears to 0.
REQ-039 Simultaneous: H=1 and branch_taken_i=1 -> if_id_flush_o=1, id_ex_flush_o=1, pc_disenabler_o=0.
REQ-040 With STALL_COUNTER_EN, CNT_BITS=2: 5 stall cycles -> stall_count_o=3; reset -> 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, memory-wait stalls and branch squashes.
// Optional stall-cycle counter is built when the STALL_COUNTER_EN macro is defined.
module hazard_stall_unit #(
  parameter int REG_BITS       = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_BITS       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_ex_mem_read_i,
  input  logic [REG_BITS-1:0] id_ex_rt_i,
  input  logic [REG_BITS-1:0] if_id_rs_i,
  input  logic [REG_BITS-1:0] if_id_rt_i,
  input  logic                mem_busy_i,
  input  logic                branch_taken_i,
  output logic                pc_disenabler_o,
  output logic                if_id_disenabler_o,
  output logic                ex_mem_disenabler_o,
  output logic                id_ex_flush_o,
  output logic                if_id_flush_o,
  output logic                mem_timeout_o
`ifdef STALL_COUNTER_EN
  ,
  output logic [CNT_BITS-1:0] stall_count_o
`endif
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;

  logic hazard;
  logic pc_dis, if_id_dis, ex_mem_dis, id_ex_flush, if_id_flush, timeout;

  assign hazard = id_ex_mem_read_i && (id_ex_rt_i != '0) &&
                  ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pend_d      = pend_q;
    pc_dis      = 1'b0;
    if_id_dis   = 1'b0;
    ex_mem_dis  = 1'b0;
    id_ex_flush = 1'b0;
    if_id_flush = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      IDLE, MEM_WAIT: begin
        if (mem_busy_i) begin
          // Memory stall freezes the front end; a branch seen now is replayed once busy drops.
          pc_dis     = 1'b1;
          if_id_dis  = 1'b1;
          ex_mem_dis = 1'b1;
          pend_d     = pend_q | branch_taken_i;
          state_d    = MEM_WAIT;
          if (state_q == MEM_WAIT) begin
            if (wait_q == WAIT_LAST) begin
              state_d = HALT;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end else begin
            wait_d = '0;
          end
        end else begin
          pc_dis      = hazard && !branch_taken_i;
          if_id_dis   = hazard && !branch_taken_i;
          id_ex_flush = hazard;
          if_id_flush = branch_taken_i | pend_q;
          pend_d      = 1'b0;
          wait_d      = '0;
          state_d     = IDLE;
        end
      end
      HALT: begin
        pc_dis     = 1'b1;
        if_id_dis  = 1'b1;
        ex_mem_dis = 1'b1;
        timeout    = 1'b1;
        pend_d     = 1'b0;
        wait_d     = '0;
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign pc_disenabler_o     = pc_dis      & reset;
  assign if_id_disenabler_o  = if_id_dis   & reset;
  assign ex_mem_disenabler_o = ex_mem_dis  & reset;
  assign id_ex_flush_o       = id_ex_flush & reset;
  assign if_id_flush_o       = if_id_flush & reset;
  assign mem_timeout_o       = timeout     & reset;

`ifdef STALL_COUNTER_EN
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pc_disenabler_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a queue of expected output vectors.
module tb_hazard_stall_unit;

  logic       clk;
  logic       reset;
  logic       id_ex_mem_read_i;
  logic [4:0] id_ex_rt_i;
  logic [4:0] if_id_rs_i;
  logic [4:0] if_id_rt_i;
  logic       mem_busy_i;
  logic       branch_taken_i;
  logic       pc_disenabler_o;
  logic       if_id_disenabler_o;
  logic       ex_mem_disenabler_o;
  logic       id_ex_flush_o;
  logic       if_id_flush_o;
  logic       mem_timeout_o;
`ifdef STALL_COUNTER_EN
  logic [1:0] stall_count_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  hazard_stall_unit #(
    .REG_BITS(5),
    .TIMEOUT_CYCLES(4),
    .CNT_BITS(2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .id_ex_mem_read_i    (id_ex_mem_read_i),
    .id_ex_rt_i          (id_ex_rt_i),
    .if_id_rs_i          (if_id_rs_i),
    .if_id_rt_i          (if_id_rt_i),
    .mem_busy_i          (mem_busy_i),
    .branch_taken_i      (branch_taken_i),
    .pc_disenabler_o     (pc_disenabler_o),
    .if_id_disenabler_o  (if_id_disenabler_o),
    .ex_mem_disenabler_o (ex_mem_disenabler_o),
    .id_ex_flush_o       (id_ex_flush_o),
    .if_id_flush_o       (if_id_flush_o),
    .mem_timeout_o       (mem_timeout_o)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count_o       (stall_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector order: {pc_dis, if_id_dis, ex_mem_dis, id_ex_flush, if_id_flush, mem_timeout}
  task automatic step(input logic busy, input logic br, input logic mr,
                      input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rtt,
                      input logic [5:0] expv, input string tag);
    logic [5:0] obs;
    logic [5:0] want;
    mem_busy_i       = busy;
    branch_taken_i   = br;
    id_ex_mem_read_i = mr;
    id_ex_rt_i       = rt;
    if_id_rs_i       = rs;
    if_id_rt_i       = rtt;
    exp_q.push_back(expv);
    @(negedge clk);
    obs  = {pc_disenabler_o, if_id_disenabler_o, ex_mem_disenabler_o,
            id_ex_flush_o, if_id_flush_o, mem_timeout_o};
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input logic [1:0] obs, input logic [1:0] want, input string tag);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, want);
    end
  endtask

  initial begin
    reset = 1'b0;
    step(1, 1, 1, 8, 8, 3, 6'b000000, "reset_outputs_zero");
    reset = 1'b1;

    step(0, 0, 1, 8, 8, 3, 6'b110100, "loaduse_rs");
    step(0, 0, 1, 5, 1, 5, 6'b110100, "loaduse_rt");
    step(0, 0, 1, 0, 0, 0, 6'b000000, "loaduse_r0");
    step(0, 0, 0, 8, 8, 8, 6'b000000, "no_load");
    step(0, 1, 1, 8, 8, 3, 6'b000110, "hazard_and_branch");
    step(0, 1, 0, 8, 8, 3, 6'b000010, "branch_only");

    step(1, 0, 1, 8, 8, 3, 6'b111000, "memwait_1");
    step(1, 0, 1, 8, 8, 3, 6'b111000, "memwait_2");
    step(1, 0, 1, 8, 8, 3, 6'b111000, "memwait_3");
    step(0, 0, 0, 0, 0, 0, 6'b000000, "memwait_release");
    step(0, 0, 0, 0, 0, 0, 6'b000000, "memwait_idle");

    step(1, 0, 0, 0, 0, 0, 6'b111000, "brwait_1");
    step(1, 1, 0, 0, 0, 0, 6'b111000, "brwait_2");
    step(1, 0, 0, 0, 0, 0, 6'b111000, "brwait_3");
    step(1, 0, 0, 0, 0, 0, 6'b111000, "brwait_4");
    step(0, 0, 0, 0, 0, 0, 6'b000010, "brwait_pulse");
    step(0, 0, 0, 0, 0, 0, 6'b000000, "brwait_pulse_end");

    step(1, 1, 0, 0, 0, 0, 6'b111000, "multibr_1");
    step(1, 1, 0, 0, 0, 0, 6'b111000, "multibr_2");
    step(0, 0, 0, 0, 0, 0, 6'b000010, "multibr_pulse");
    step(0, 0, 0, 0, 0, 0, 6'b000000, "multibr_single");

    step(1, 1, 0, 0, 0, 0, 6'b111000, "rstwait_1");
    step(1, 0, 0, 0, 0, 0, 6'b111000, "rstwait_2");
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 6'b000000, "rstwait_in_reset");
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 6'b000000, "rstwait_no_pulse");

    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 6'b111000, "timeout_wait");
    end
    step(1, 0, 0, 0, 0, 0, 6'b111001, "timeout_halt");
    step(0, 1, 1, 8, 8, 3, 6'b111001, "halt_sticky_inputs");
    step(0, 0, 0, 0, 0, 0, 6'b111001, "halt_sticky_idle");
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 6'b000000, "halt_reset");
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 6'b000000, "after_halt");
    step(0, 0, 1, 8, 8, 3, 6'b110100, "after_halt_loaduse");

`ifdef STALL_COUNTER_EN
    reset = 1'b0;
    @(negedge clk);
    chk_cnt(stall_count_o, 2'd0, "cnt_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8, 8, 3, 6'b110100, "cnt_stall");
    end
    id_ex_mem_read_i = 1'b0;
    @(negedge clk);
    chk_cnt(stall_count_o, 2'd3, "cnt_saturate");
    reset = 1'b0;
    #1;
    chk_cnt(stall_count_o, 2'd0, "cnt_reset_clear");
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
